// File: rtl/lsu_pkg.sv
// Shared RV32I load/store funct3 encodings and the LSU controller state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends a load result from a word and merges sub-word store data into a word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_ld_data = i_word;
        case (i_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_word;
        endcase
    end

    // Only the addressed lanes change; the rest of the word comes from the prior read.
    always_comb begin
        o_st_word = i_word;
        case (i_funct3)
            F3_SB:   o_st_word[{i_off, 3'b000} +: 8]       = i_wdata[7:0];
            F3_SH:   o_st_word[{i_off[1], 4'b0000} +: 16]  = i_wdata[15:0];
            default: o_st_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: sized/signed loads, read-modify-write SB/SH, fault detection.
// Accept->resp latency 2 (loads, SW), 3 (SB/SH), 1 (fault); req_ready only in IDLE, response held until resp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_ADDR_W = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault
);

    lsu_state_t               r_state;
    logic                     r_store;
    logic [2:0]               r_funct3;
    logic [WORD_ADDR_W+1:0]   r_addr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_word;
    logic                     r_resp_valid;
    logic                     r_resp_fault;
    logic [31:0]              r_resp_data;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_oob;
    logic        w_fault;
    logic        w_is_sw;
    logic        w_rd;
    logic        w_wr;
    logic [31:0] w_align_word;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_word;

    assign w_illegal  = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                  : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oob      = |req_addr[31:WORD_ADDR_W+2];
    assign w_fault    = w_illegal || w_misalign || w_oob;

    assign w_is_sw = r_store && (r_funct3 == F3_SW);

    // Strobes are gated by reset so an aborted SW/MERGE never writes on the reset edge.
    assign w_rd = reset && (r_state == ST_ACCESS);
    assign w_wr = reset && (((r_state == ST_ACCESS) && w_is_sw) || (r_state == ST_MERGE));

    assign mem_read    = w_rd;
    assign mem_write   = w_wr;
    assign mem_addr    = (w_rd || w_wr) ? {{(32-WORD_ADDR_W){1'b0}}, r_addr[WORD_ADDR_W+1:2]} : 32'd0;
    assign mem_wr_data = !w_wr ? 32'd0 : ((r_state == ST_MERGE) ? w_st_word : r_wdata);

    assign w_align_word = (r_state == ST_MERGE) ? r_word : mem_data;

    lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_off     (r_addr[1:0]),
        .i_word    (w_align_word),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld_data),
        .o_st_word (w_st_word)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_fault = r_resp_fault;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_word       <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[WORD_ADDR_W+1:0];
                        r_wdata  <= req_wdata;
                        if (w_fault) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_data  <= 32'd0;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_word <= mem_data;
                    if (r_store && !w_is_sw) begin
                        r_state <= ST_MERGE;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b0;
                        r_resp_data  <= r_store ? 32'd0 : w_ld_data;
                    end
                end
                ST_MERGE: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_data  <= 32'd0;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_fault <= 1'b0;
                        r_resp_data  <= 32'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32-word data memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_fault;

    load_store_unit #(.WORD_ADDR_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_data    (mem_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_fault  (resp_fault)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [32];
    logic        preload = 1'b1;
    logic [31:0] last_wr = 32'd0;

    assign mem_data = mem[mem_addr[4:0]];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h0000_017D;
            mem[1] <= 32'h8000_F0AB;
            mem[2] <= 32'h1122_3344;
            mem[3] <= 32'hDEAD_BEEF;
        end else if (mem_write) begin
            mem[mem_addr[4:0]] <= mem_wr_data;
            last_wr            <= mem_wr_data;
        end
    end

    int total = 0;
    int bad   = 0;
    logic saw_rd = 1'b0;
    logic saw_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        saw_rd = saw_rd | mem_read;
        saw_wr = saw_wr | mem_write;
    endtask

    // Issues one request and returns cycles from accept edge to first resp_valid (-1 on timeout).
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        saw_rd = 1'b0; saw_wr = 1'b0;
        tick();
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        lat = 1;
        while (!resp_valid && lat < 20) begin tick(); lat++; end
        if (!resp_valid) lat = -1;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        logic        chk_mem;
        int          widx;
        logic [31:0] wval;
    } vec_t;

    vec_t vec [14];
    int   lat;

    initial begin
        vec[0]  = '{1'b0, 3'b000, 32'h0,  32'h0,        32'h0000_007D, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[1]  = '{1'b0, 3'b001, 32'h6,  32'h0,        32'hFFFF_8000, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[2]  = '{1'b0, 3'b101, 32'h6,  32'h0,        32'h0000_8000, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[3]  = '{1'b0, 3'b100, 32'h4,  32'h0,        32'h0000_00AB, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[4]  = '{1'b0, 3'b000, 32'h5,  32'h0,        32'hFFFF_FFF0, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[5]  = '{1'b0, 3'b010, 32'h4,  32'h0,        32'h8000_F0AB, 1'b0, 2, 1'b0, 0, 32'h0};
        vec[6]  = '{1'b0, 3'b010, 32'h2,  32'h0,        32'h0,         1'b1, 1, 1'b0, 0, 32'h0};
        vec[7]  = '{1'b1, 3'b001, 32'h3,  32'h1234,     32'h0,         1'b1, 1, 1'b0, 0, 32'h0};
        vec[8]  = '{1'b0, 3'b010, 32'h80, 32'h0,        32'h0,         1'b1, 1, 1'b0, 0, 32'h0};
        vec[9]  = '{1'b0, 3'b011, 32'h0,  32'h0,        32'h0,         1'b1, 1, 1'b0, 0, 32'h0};
        vec[10] = '{1'b1, 3'b100, 32'h0,  32'h0,        32'h0,         1'b1, 1, 1'b0, 0, 32'h0};
        vec[11] = '{1'b1, 3'b000, 32'h9,  32'hFF,       32'h0,         1'b0, 3, 1'b1, 2, 32'h1122_FF44};
        vec[12] = '{1'b1, 3'b010, 32'hC,  32'hCAFE_F00D, 32'h0,        1'b0, 2, 1'b1, 3, 32'hCAFE_F00D};
        vec[13] = '{1'b1, 3'b001, 32'hE,  32'h0000_1234, 32'h0,        1'b0, 3, 1'b1, 3, 32'h1234_F00D};

        tick(); tick();
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_data",  resp_data,           32'd0);
        chk("rst_strobes",    {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        chk("rst_mem_wdata",  mem_wr_data,         32'd0);
        preload = 1'b0;
        reset   = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            do_txn(vec[i].store, vec[i].f3, vec[i].addr, vec[i].wdata, lat);
            chk($sformatf("v%0d_latency", i), lat, vec[i].exp_lat);
            chk($sformatf("v%0d_resp_data", i), resp_data, vec[i].exp_data);
            chk($sformatf("v%0d_resp_fault", i), {31'd0, resp_fault}, {31'd0, vec[i].exp_fault});
            if (vec[i].exp_fault)
                chk($sformatf("v%0d_no_strobes", i), {30'd0, saw_rd, saw_wr}, 32'd0);
            release_resp();
            chk($sformatf("v%0d_idle", i), {30'd0, req_ready, resp_valid}, 32'd2);
            if (vec[i].chk_mem) begin
                chk($sformatf("v%0d_mem_word", i), mem[vec[i].widx], vec[i].wval);
                chk($sformatf("v%0d_wr_data", i), last_wr, vec[i].wval);
            end
        end

        // Read back the word built by SW then SH.
        do_txn(1'b0, 3'b010, 32'hC, 32'h0, lat);
        chk("lw_after_sh", resp_data, 32'h1234_F00D);
        release_resp();

        // Response must hold while resp_ready stays low.
        do_txn(1'b0, 3'b000, 32'h0, 32'h0, lat);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("stall%0d", c),
                {resp_valid, resp_fault, req_ready, 29'd0} ^ resp_data,
                {1'b1, 1'b0, 1'b0, 29'd0} ^ 32'h0000_007D);
        end
        release_resp();
        chk("stall_release", {30'd0, req_ready, resp_valid}, 32'd2);

        // Reset asserted while the SH merge write is on the bus.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4; req_wdata = 32'h5555;
        tick();
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        tick();
        chk("merge_strobe", {31'd0, mem_write}, 32'd1);
        chk("merge_wdata",  mem_wr_data, 32'h8000_5555);
        reset = 1'b0;
        tick();
        chk("abort_word1",   mem[1], 32'h8000_F0AB);
        chk("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("abort_ready",   {30'd0, req_ready, resp_valid}, 32'd2);
        reset = 1'b1;
        tick(); tick();
        chk("abort_word1_later", mem[1], 32'h8000_F0AB);
        chk("abort_idle", {30'd0, req_ready, resp_valid}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
